// File: rtl/multi_byte_sub_ctrl.sv
// multi_byte_sub_ctrl
// Computes a - b over NBYTES bytes by reusing one external 8-bit subtractor
// (subEight, no borrow-in), least significant byte first. When a byte is
// entered with a pending borrow, the block makes a second pass through the
// same subtractor to compute byte - 1.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only in IDLE
//   a, b                minuend / subtrahend, latched on accepted start
//   busy                high while bytes are processed (SUB/DEC)
//   done                one-cycle pulse, result valid
//   result, borrowOut   difference and final borrow, held until next start
//   zero                result == 0 (only with SUBSEQ_ZERO_FLAG_EN)
//   subD0/subD1/subEnable  operands and enable to subEight
//   subDOut/subBOut     difference and borrow from subEight
//
// Build option: define SUBSEQ_ZERO_FLAG_EN to add the zero flag port.
module multi_byte_sub_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  borrowOut,
`ifdef SUBSEQ_ZERO_FLAG_EN
    output logic                  zero,
`endif
    output logic [7:0]            subD0,
    output logic [7:0]            subD1,
    output logic                  subEnable,
    input  logic [7:0]            subDOut,
    input  logic                  subBOut
);

    localparam int unsigned IDX_W = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, SUB, DEC, DONE} state_t;

    state_t                    state, state_n;
    logic [IDX_W-1:0]          idx, idx_n;
    logic                      br, br_n;
    logic [NBYTES-1:0][7:0]    op_a, op_a_n;
    logic [NBYTES-1:0][7:0]    op_b, op_b_n;
    logic [NBYTES-1:0][7:0]    res, res_n;
    logic                      bo_n;
    logic                      busy_n;
    logic                      done_n;
    logic [7:0]                d0_n;
    logic [7:0]                d1_n;
    logic                      en_n;
    logic                      last;
`ifdef SUBSEQ_ZERO_FLAG_EN
    logic                      zero_n;
`endif

    assign last   = (idx == IDX_W'(NBYTES - 1));
    assign result = res;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            br        <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            borrowOut <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            subD0     <= 8'h00;
            subD1     <= 8'h00;
            subEnable <= 1'b0;
`ifdef SUBSEQ_ZERO_FLAG_EN
            zero      <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            br        <= br_n;
            op_a      <= op_a_n;
            op_b      <= op_b_n;
            res       <= res_n;
            borrowOut <= bo_n;
            busy      <= busy_n;
            done      <= done_n;
            subD0     <= d0_n;
            subD1     <= d1_n;
            subEnable <= en_n;
`ifdef SUBSEQ_ZERO_FLAG_EN
            zero      <= zero_n;
`endif
        end
    end

    // Next state, datapath updates, and next values of the registered outputs
    always_comb begin
        state_n = state;
        idx_n   = idx;
        br_n    = br;
        op_a_n  = op_a;
        op_b_n  = op_b;
        res_n   = res;
        bo_n    = borrowOut;
`ifdef SUBSEQ_ZERO_FLAG_EN
        zero_n  = zero;
`endif
        busy_n  = 1'b0;
        done_n  = 1'b0;
        d0_n    = 8'h00;
        d1_n    = 8'h00;
        en_n    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    op_a_n  = a;
                    op_b_n  = b;
                    res_n   = '0;
                    idx_n   = '0;
                    br_n    = 1'b0;
                    bo_n    = 1'b0;
`ifdef SUBSEQ_ZERO_FLAG_EN
                    zero_n  = 1'b0;
`endif
                    state_n = SUB;
                end
            end
            SUB: begin
                res_n[idx] = subDOut;
                // A pending borrow forces a DEC pass; br then carries this
                // byte's own borrow until DEC merges in the second one.
                br_n = subBOut;
                if (br) begin
                    state_n = DEC;
                end else if (last) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    state_n = SUB;
                end
            end
            DEC: begin
                res_n[idx] = subDOut;
                br_n       = br | subBOut;
                if (last) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    state_n = SUB;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Final flags are captured on the edge that enters DONE
        if (state_n == DONE && state != DONE) begin
            bo_n = br_n;
`ifdef SUBSEQ_ZERO_FLAG_EN
            zero_n = (res_n == '0);
`endif
        end

        // Outputs reflect the state being entered so they align with it
        case (state_n)
            SUB: begin
                d0_n   = op_a_n[idx_n];
                d1_n   = op_b_n[idx_n];
                en_n   = 1'b1;
                busy_n = 1'b1;
            end
            DEC: begin
                d0_n   = res_n[idx_n];
                d1_n   = 8'h01;
                en_n   = 1'b1;
                busy_n = 1'b1;
            end
            DONE: begin
                done_n = 1'b1;
            end
            default: begin
                en_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_byte_sub_ctrl.sv
// Directed testbench for multi_byte_sub_ctrl (NBYTES=4) with a behavioural
// subEight model. Zero-flag checks run when SUBSEQ_ZERO_FLAG_EN is defined.
module tb_multi_byte_sub_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        borrow_out;
`ifdef SUBSEQ_ZERO_FLAG_EN
    logic        zero;
`endif
    logic [7:0]  sub_d0;
    logic [7:0]  sub_d1;
    logic        sub_en;
    logic [7:0]  sub_dout;
    logic        sub_bout;

    int errors = 0;
    int checks = 0;

    multi_byte_sub_ctrl #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .borrowOut (borrow_out),
`ifdef SUBSEQ_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .subD0     (sub_d0),
        .subD1     (sub_d1),
        .subEnable (sub_en),
        .subDOut   (sub_dout),
        .subBOut   (sub_bout)
    );

    // subEight model: output gated to zero when not enabled
    assign sub_dout = sub_en ? (sub_d0 - sub_d1) : 8'h00;
    assign sub_bout = sub_en & (sub_d0 < sub_d1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to done; a/b are scrambled after acceptance
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er, input logic eb, input int ek);
        int  cyc;
        int  en;
        bit  got;
        cyc = 0;
        en  = 0;
        got = 1'b0;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av;
        b = 32'hA5A5_5A5A;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check({tag, "_d0_first"}, 64'(sub_d0), 64'(av[7:0]));
                check({tag, "_d1_first"}, 64'(sub_d1), 64'(bv[7:0]));
            end
            if (sub_en) en++;
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(got), 64'(1));
        check({tag, "_latency"}, 64'(cyc - 1), 64'(ek));
        check({tag, "_enable_cycles"}, 64'(en), 64'(ek));
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_borrow"}, 64'(borrow_out), 64'(eb));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
        check({tag, "_result_held"}, 64'(result), 64'(er));
        check({tag, "_borrow_held"}, 64'(borrow_out), 64'(eb));
    endtask

    initial begin
        int cyc;
        bit got;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_borrow", 64'(borrow_out), 64'(0));
        check("rst_en", 64'(sub_en), 64'(0));
        check("rst_d0", 64'(sub_d0), 64'(0));
        check("rst_d1", 64'(sub_d1), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // No borrow chain, minimum latency
        run_op("t1", 32'h1234_5678, 32'h0000_0001, 32'h1234_5677, 1'b0, 4);
        // One DEC pass on byte 1
        run_op("t2", 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 5);
        // Maximum latency, full borrow ripple
        run_op("t3", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 7);
        // Borrow cleared by next accepted start
        run_op("t4", 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 7);

        // start held high, operands changed mid-operation
        @(negedge clk);
        a = 32'h0000_0100; b = 32'h0000_0001; start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h5555_5555; b = 32'h1111_1111;
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
        check("hold_latency", 64'(cyc - 1), 64'(5));
        check("hold_result", 64'(result), 64'(32'h0000_00FF));
        @(negedge clk);
        check("hold_idle_busy", 64'(busy), 64'(0));
        check("hold_idle_result", 64'(result), 64'(32'h0000_00FF));
        @(negedge clk);
        check("hold_reaccept_busy", 64'(busy), 64'(1));
        check("hold_reaccept_clear", 64'(result[31:8]), 64'(0));
        start = 1'b0;
        cyc = 1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
        check("hold2_latency", 64'(cyc - 1), 64'(4));
        check("hold2_result", 64'(result), 64'(32'h4444_4444));

        // Asynchronous reset during SUB of byte 2
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h0000_0001; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_result", 64'(result), 64'(0));
        check("arst_borrow", 64'(borrow_out), 64'(0));
        check("arst_en", 64'(sub_en), 64'(0));
        check("arst_d0", 64'(sub_d0), 64'(0));
`ifdef SUBSEQ_ZERO_FLAG_EN
        check("arst_zero", 64'(zero), 64'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) got = 1'b1;
        end
        check("arst_no_done", 64'(got), 64'(0));
        run_op("t5", 32'h0001_0000, 32'h0000_0002, 32'h0000_FFFE, 1'b0, 6);

`ifdef SUBSEQ_ZERO_FLAG_EN
        run_op("z1", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 4);
        check("z1_zero", 64'(zero), 64'(1));
        run_op("z2", 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 4);
        check("z2_zero", 64'(zero), 64'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_byte_sub_ctrl.md
# multi_byte_sub_ctrl

Sequencer that performs NBYTES-wide subtraction (a − b) by time-multiplexing one shared 8-bit subtractor (`subEight`, no borrow-in) over successive bytes, LSB first. An incoming borrow is folded in by a second pass through the same subtractor, computing byte − 1. The block sits between the CPU execute stage and the single `subEight` instance, and owns that instance's operand and enable inputs.

## Interface
- NBYTES, default 4: operand width in bytes; legal range 2–8.

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  8*NBYTES  minuend; latched on accepted start
- b  in  8*NBYTES  subtrahend; latched on accepted start
- busy  out  1  high in SUB/DEC states
- done  out  1  one-cycle pulse when result is valid
- result  out  8*NBYTES  difference; holds until next accepted start
- borrowOut  out  1  final borrow (a < b unsigned); holds with result
- zero  out  1  result == 0; present only with SUBSEQ_ZERO_FLAG_EN
- subD0  out  8  to `subEight` d0
- subD1  out  8  to `subEight` d1
- subEnable  out  1  to `subEight` enable
- subDOut  in  8  from `subEight` dOut
- subBOut  in  1  from `subEight` bOut

## Operation
- States: IDLE, SUB, DEC, DONE. Internal: byte index idx, running borrow br, latched opA/opB.
- IDLE: subEnable=0, subD0/subD1=0. start=1 → latch a, b; clear result to 0; idx=0, br=0 → SUB.
- SUB: subD0=opA[idx], subD1=opB[idx], subEnable=1. Edge: result[idx]=subDOut, b1=subBOut.
  - br=0 → br=b1; if idx=NBYTES−1 → DONE, else idx+1 → SUB.
  - br=1 → hold b1 → DEC.
- DEC: subD0=result[idx], subD1=8'h01, subEnable=1. Edge: result[idx]=subDOut, br=b1|subBOut; then same last-byte/advance rule as SUB.
- DONE: done=1, subEnable=0, borrowOut=br → IDLE. start is ignored in DONE.
- start while busy or in DONE: ignored; no effect on latched operands or result.
- Byte 0 never enters DEC, because br=0 at entry.
- subDOut is ignored whenever subEnable=0. It is gated to 0 by the datapath.
- Changes to a/b after the accepted start have no effect.

## Timing
- Reset (async, rst_n=0): state=IDLE. busy, done, result, borrowOut, zero, subD0, subD1 and subEnable are all 0. The reset takes effect immediately, including mid-operation; the partial result is discarded.
- Start sampled at edge E0. Busy cycles k = NBYTES + (number of DEC passes).
  - Minimum: k = NBYTES.
  - Maximum: k = 2·NBYTES−1.
- done is high for exactly one cycle, from edge E0+k to E0+k+1. busy falls at E0+k.
- result bytes update progressively while busy. Consumers sample only on done.
- Earliest next accepted start: edge E0+k+2 (after DONE → IDLE).
- borrowOut updates at E0+k and holds until the next reset or accepted start. It clears to 0 on an accepted start.

## Configuration
- SUBSEQ_ZERO_FLAG_EN defined:
  - `zero` port exists.
  - Registered at the DONE transition: 1 iff the final result is all zero.
  - Cleared to 0 on reset and on an accepted start.
- SUBSEQ_ZERO_FLAG_EN undefined: `zero` port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use NBYTES=4.
- a=0x12345678, b=0x00000001 → result=0x12345677, borrowOut=0, done at E0+4, subEnable high for 4 cycles.
- a=0x00000100, b=0x00000001 → result=0x000000FF, borrowOut=0, one DEC pass on byte 1, done at E0+5.
- a=0x00000000, b=0x00000001 → result=0xFFFFFFFF, borrowOut=1, DEC passes on bytes 1–3, done at E0+7.
- start held high throughout, with a/b changed mid-operation → only the first request is accepted; result matches the original operands; the next acceptance occurs at E0+k+2.
- rst_n pulsed low during the SUB of byte 2 → all outputs read 0 immediately, state is IDLE, no done pulse; a fresh start then completes normally.
- With SUBSEQ_ZERO_FLAG_EN: a=b=0xDEADBEEF → result=0, borrowOut=0, zero=1; a following request with a=5, b=3 → zero=0 on its done.
